// File: rtl/bp_clint_multi.sv
// Multi-hart core-local interruptor: msip, mtimecmp and mtime registers behind a
// single-outstanding command/response port, with per-hart software and timer interrupts.
module bp_clint_multi #(
  parameter int unsigned num_core_p    = 4,
  parameter int unsigned paddr_width_p = 56,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned tick_div_p    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  input  logic                     mem_cmd_w_i,
  input  logic [1:0]               mem_cmd_size_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic [data_width_p-1:0]  mem_cmd_data_i,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_ready_i,
  output logic [data_width_p-1:0]  mem_resp_data_o,
  output logic                     mem_resp_err_o,
  output logic [num_core_p-1:0]    soft_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o
);

  localparam int unsigned IW = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam int unsigned PW = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e                  state;
  logic [num_core_p-1:0]   msip;
  logic [63:0]             mtimecmp [num_core_p];
  logic [63:0]             mtime;
  logic [PW-1:0]           presc;
  logic [num_core_p-1:0]   timer_irq;
  logic [63:0]             resp_data;
  logic                    resp_err;

  logic [23:0]   offset_c;
  logic [11:0]   msip_idx_c;
  logic [10:0]   cmp_idx_c;
  logic [IW-1:0] hart_c;
  logic          is_8b_c, size_ok_c;
  logic          hit_msip_c, hit_cmp_c, hit_mtime_c, err_c;
  logic          accept_c, wr_c, tick_c;
  logic [63:0]   sel_c, rdata_c, wval_c;
  logic          unused_addr_c;

  assign offset_c      = mem_cmd_addr_i[23:0];
  assign msip_idx_c    = offset_c[13:2];
  assign cmp_idx_c     = offset_c[13:3];
  assign unused_addr_c = ^mem_cmd_addr_i[paddr_width_p-1:24];
  assign accept_c      = mem_cmd_v_i && (state == ST_IDLE);
  assign wr_c          = accept_c && mem_cmd_w_i && !err_c;
  assign tick_c        = (presc == PW'(tick_div_p - 1));

  // Address decode, error classification, read mux and merged write value
  always_comb begin
    is_8b_c     = (mem_cmd_size_i == 2'd3);
    size_ok_c   = (mem_cmd_size_i == 2'd2) || is_8b_c;
    hit_msip_c  = (offset_c[23:14] == 10'd0) && (32'(msip_idx_c) < num_core_p);
    hit_cmp_c   = (offset_c[23:14] == 10'd1) && (32'(cmp_idx_c) < num_core_p);
    hit_mtime_c = (offset_c[23:3] == 21'h17FF);
    hart_c      = hit_msip_c ? IW'(msip_idx_c) : IW'(cmp_idx_c);
    err_c       = !size_ok_c || (offset_c[1:0] != 2'd0) || (is_8b_c && offset_c[2])
                  || !(hit_msip_c || hit_cmp_c || hit_mtime_c) || (hit_msip_c && is_8b_c);
    sel_c       = mtime;
    if (hit_msip_c)     sel_c = {63'd0, msip[hart_c]};
    else if (hit_cmp_c) sel_c = mtimecmp[hart_c];
    rdata_c = sel_c;
    if (!is_8b_c && !hit_msip_c)
      rdata_c = offset_c[2] ? {32'd0, sel_c[63:32]} : {32'd0, sel_c[31:0]};
    wval_c = mem_cmd_data_i;
    if (!is_8b_c)
      wval_c = offset_c[2] ? {mem_cmd_data_i[31:0], sel_c[31:0]}
                           : {sel_c[63:32], mem_cmd_data_i[31:0]};
  end

  // Request/response handshake; response captured on the acceptance edge
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mem_cmd_v_i) begin
          state     <= ST_RESP;
          resp_err  <= err_c;
          resp_data <= (mem_cmd_w_i || err_c) ? 64'd0 : rdata_c;
        end
        ST_RESP: if (mem_resp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Timebase, compare registers, software-interrupt bits and timer comparators
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc     <= '0;
      mtime     <= '0;
      msip      <= '0;
      timer_irq <= '0;
      for (int i = 0; i < int'(num_core_p); i++) mtimecmp[i] <= '1;
    end else begin
      presc <= tick_c ? '0 : presc + PW'(1);
      if (wr_c && hit_mtime_c) mtime <= wval_c;
      else if (tick_c)         mtime <= mtime + 64'd1;
      for (int i = 0; i < int'(num_core_p); i++) begin
        if (wr_c && hit_cmp_c && (hart_c == IW'(i)))  mtimecmp[i] <= wval_c;
        if (wr_c && hit_msip_c && (hart_c == IW'(i))) msip[i] <= mem_cmd_data_i[0];
        timer_irq[i] <= (mtime >= mtimecmp[i]);
      end
    end
  end

  assign mem_cmd_ready_o = (state == ST_IDLE);
  assign mem_resp_v_o    = (state == ST_RESP);
  assign mem_resp_data_o = resp_data;
  assign mem_resp_err_o  = resp_err;
  assign soft_irq_o      = msip;
  assign timer_irq_o     = timer_irq;

endmodule

// File: tb/tb_bp_clint_multi.sv
// Randomized bench for bp_clint_multi against an arithmetic model of the register map
// and timebase (mtime derived from edge count since the last write).
module tb_bp_clint_multi;

  localparam int unsigned N  = 4;
  localparam int unsigned T  = 8;
  localparam int          TI = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_v = 1'b0, cmd_w = 1'b0, resp_ready = 1'b0;
  logic [1:0]  cmd_size = 2'd0;
  logic [55:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        cmd_ready, resp_v, resp_err;
  logic [63:0] resp_data;
  logic [N-1:0] soft_irq, timer_irq;

  always #5 clk = ~clk;

  bp_clint_multi #(.num_core_p(N), .paddr_width_p(56), .data_width_p(64), .tick_div_p(T)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_ready), .mem_cmd_w_i(cmd_w),
    .mem_cmd_size_i(cmd_size), .mem_cmd_addr_i(cmd_addr), .mem_cmd_data_i(cmd_data),
    .mem_resp_v_o(resp_v), .mem_resp_ready_i(resp_ready),
    .mem_resp_data_o(resp_data), .mem_resp_err_o(resp_err),
    .soft_irq_o(soft_irq), .timer_irq_o(timer_irq)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edges since reset release
  int ecnt;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;

  logic [63:0]  m_cmp [N];
  logic [N-1:0] m_msip;
  logic [63:0]  m_wval;
  int           m_wedge;
  logic [N-1:0] prev_irq;
  bit           prev_valid = 0;

  // mtime after edge n: last written value plus ticks (every T-th edge) since the write
  function automatic logic [63:0] mt(input int n);
    return m_wval + 64'(n / TI - m_wedge / TI);
  endfunction

  task automatic model_reset();
    m_wval = '0; m_wedge = 0; m_msip = '0;
    for (int i = 0; i < int'(N); i++) m_cmp[i] = '1;
  endtask

  // Timer interrupts reflect the previous cycle's mtime/mtimecmp
  always @(negedge clk) begin
    if (!reset_n) prev_valid = 0;
    else begin
      check_eq("timer_irq", 64'(timer_irq), prev_valid ? 64'(prev_irq) : 64'd0);
      for (int i = 0; i < int'(N); i++) prev_irq[i] = (mt(ecnt) >= m_cmp[i]);
      prev_valid = 1;
    end
  end

  // kind: 0 msip, 1 mtimecmp, 2 mtime, 3 unmapped
  function automatic void decode(input logic [1:0] size, input logic [55:0] addr,
                                 output bit err, output int kind, output int h);
    int off;
    off  = int'(addr[23:0]);
    kind = 3; h = 0;
    if (off < 'h4000 && off / 4 < int'(N)) begin kind = 0; h = off / 4; end
    else if (off >= 'h4000 && off < 'h4000 + 8 * int'(N)) begin kind = 1; h = (off - 'h4000) / 8; end
    else if (off == 'hBFF8 || off == 'hBFFC) kind = 2;
    err = !(size == 2'd2 || size == 2'd3) || (off % 4 != 0) || (size == 2'd3 && off % 8 != 0)
          || kind == 3 || (kind == 0 && size == 2'd3);
  endfunction

  task automatic xact(input bit w, input logic [1:0] size, input logic [55:0] addr,
                      input logic [63:0] data, input int hold,
                      output logic [63:0] rd, output logic rerr);
    bit e; int k, h, acc, guard;
    logic [63:0] sel, exp_d, nv;
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = w; cmd_size = size; cmd_addr = addr; cmd_data = data;
    resp_ready = (hold == 0);
    guard = 0;
    while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) begin
      check_eq("accept_timeout", 64'd0, 64'd1);
      cmd_v = 1'b0; rd = '0; rerr = 1'b1;
      return;
    end
    acc = ecnt + 1;
    decode(size, addr, e, k, h);
    sel = 64'd0;
    if (k == 0)      sel = {63'd0, m_msip[h]};
    else if (k == 1) sel = m_cmp[h];
    else if (k == 2) sel = mt(acc - 1);
    if (w || e)                     exp_d = 64'd0;
    else if (k == 0 || size == 2'd3) exp_d = sel;
    else exp_d = addr[2] ? {32'd0, sel[63:32]} : {32'd0, sel[31:0]};
    if (size == 2'd3) nv = data;
    else nv = addr[2] ? {data[31:0], sel[31:0]} : {sel[63:32], data[31:0]};
    @(posedge clk); #1;
    cmd_v = 1'b0;
    if (w && !e) begin
      case (k)
        0:       m_msip[h] = data[0];
        1:       m_cmp[h] = nv;
        default: begin m_wval = nv; m_wedge = acc; end
      endcase
    end
    check_eq("resp_v", 64'(resp_v), 64'd1);
    check_eq("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
    check_eq("resp_err", 64'(resp_err), 64'(e));
    check_eq("resp_data", resp_data, exp_d);
    check_eq("soft_irq", 64'(soft_irq), 64'(m_msip));
    rd = resp_data; rerr = resp_err;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        cmd_v = 1'b1; cmd_w = 1'b1; cmd_size = 2'd3; cmd_addr = 56'h4018; cmd_data = 64'd0;
        check_eq("hold_resp_v", 64'(resp_v), 64'd1);
        check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("hold_data", resp_data, rd);
        check_eq("hold_err", 64'(resp_err), 64'(rerr));
      end
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    cmd_v = 1'b0;
    check_eq("resp_done", 64'(resp_v), 64'd0);
  endtask

  logic [63:0] rd;
  logic        re;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    #1;
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rst_resp_v", 64'(resp_v), 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    check_eq("rst_resp_data", resp_data, 64'd0);
    check_eq("rst_soft_irq", 64'(soft_irq), 64'd0);
    check_eq("rst_timer_irq", 64'(timer_irq), 64'd0);

    // msip write of all ones keeps only bit 0
    xact(1'b1, 2'd2, 56'h8, 64'hFFFF_FFFF, 0, rd, re);
    xact(1'b0, 2'd2, 56'h8, 64'd0, 0, rd, re);
    check_eq("msip2_read", rd, 64'd1);
    check_eq("msip2_err", 64'(re), 64'd0);
    check_eq("msip2_soft", 64'(soft_irq), 64'b0100);

    // error cases leave state alone
    xact(1'b0, 2'd3, 56'h4004, 64'd0, 0, rd, re);
    check_eq("mis8_err", 64'(re), 64'd1);
    check_eq("mis8_data", rd, 64'd0);
    xact(1'b1, 2'd2, 56'h14, 64'd1, 0, rd, re);
    check_eq("msip5_err", 64'(re), 64'd1);
    check_eq("msip5_soft", 64'(soft_irq), 64'b0100);

    // mtimecmp[1] = 0x10 fires hart 1 only
    xact(1'b1, 2'd3, 56'h4008, 64'h10, 0, rd, re);
    begin
      int g = 0;
      while (!timer_irq[1] && g < 400) begin @(negedge clk); g++; end
      check_eq("cmp1_fire_in_time", 64'(g < 400), 64'd1);
    end
    check_eq("cmp1_only_hart1", 64'(timer_irq), 64'b0010);
    xact(1'b0, 2'd3, 56'hBFF8, 64'd0, 0, rd, re);
    check_eq("mtime_past_cmp1", 64'(rd >= 64'h10), 64'd1);

    // backpressured read; intruding write to mtimecmp[3] must be dropped
    xact(1'b0, 2'd3, 56'hBFF8, 64'd0, 5, rd, re);
    xact(1'b0, 2'd3, 56'h4018, 64'd0, 0, rd, re);
    check_eq("intruder_dropped", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    // mtime writes on the increment edge are exact; all-ones wraps to 0
    @(negedge clk);
    while ((ecnt + 2) % TI != 0) @(negedge clk);
    xact(1'b1, 2'd3, 56'hBFF8, 64'h0123_4567_89AB_CDEF, 0, rd, re);
    xact(1'b0, 2'd3, 56'hBFF8, 64'd0, 0, rd, re);
    check_eq("mtime_exact", rd, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    while ((ecnt + 2) % TI != 0) @(negedge clk);
    xact(1'b1, 2'd3, 56'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, re);
    xact(1'b0, 2'd3, 56'hBFF8, 64'd0, 0, rd, re);
    check_eq("mtime_ones", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (T) @(negedge clk);
    xact(1'b0, 2'd3, 56'hBFF8, 64'd0, 0, rd, re);
    check_eq("mtime_wrap", rd, 64'd0);

    // randomized mix of legal and illegal accesses
    for (int it = 0; it < 160; it++) begin
      logic [55:0] a; logic [1:0] sz; logic [63:0] d; int hh, sr;
      hh = int'($urandom_range(0, 5));
      case ($urandom_range(0, 5))
        0: a = 56'(4 * hh);
        1: a = 56'('h4000 + 8 * hh + 4 * int'($urandom_range(0, 1)));
        2: a = 56'('hBFF8 + 4 * int'($urandom_range(0, 1)));
        3: a = 56'($urandom_range(0, 'hFFFF));
        4: a = 56'(4 * hh) | 56'($urandom_range(1, 3));
        default: a = {32'($urandom), 24'('h4000 + 8 * hh)};
      endcase
      sr = int'($urandom_range(0, 9));
      sz = (sr <= 4) ? 2'd2 : (sr <= 8) ? 2'd3 : 2'($urandom_range(0, 1));
      d  = {32'($urandom), 32'($urandom)};
      if (a[23:0] >= 24'h4000) begin
        d = mt(ecnt) + 64'($urandom_range(0, 6));
        if (sz == 2'd2 && a[2]) d = {32'd0, d[63:32]};
      end
      xact(1'($urandom_range(0, 1)), sz, a, d, int'($urandom_range(0, 3) == 0 ? 2 : 0), rd, re);
    end

    // reset during a pending write response
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = 1'b1; cmd_size = 2'd3; cmd_addr = 56'h4000; cmd_data = 64'd5;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    check_eq("pre_rst_resp_v", 64'(resp_v), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_resp_v", 64'(resp_v), 64'd0);
    check_eq("async_resp_data", resp_data, 64'd0);
    check_eq("async_timer_irq", 64'(timer_irq), 64'd0);
    check_eq("async_soft_irq", 64'(soft_irq), 64'd0);
    model_reset();
    @(negedge clk); #2 reset_n = 1'b1;
    #1;
    check_eq("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    check_eq("rel_resp_v", 64'(resp_v), 64'd0);
    xact(1'b0, 2'd3, 56'h4000, 64'd0, 0, rd, re);
    check_eq("cmp0_after_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
